dcache_wb_mem_bridge: RTL
=========================

Name: dcache_wb_mem_bridge

Overview:
- Sits between the write-back data cache (datapath plus controller) and the line-wide data memory port.
- Buffers evicted dirty lines in a small write-back FIFO and drains them to memory when idle.
- Serves line-fill reads ahead of pending write-backs, forwarding from the buffer when the line is still held there.
- Decouples eviction from allocation, so a miss with a dirty victim costs one memory read instead of write-then-read.

Parameters:
- DCACHE_ADDR_WIDTH, 32, byte address width.
- DCACHE_LINE_WIDTH, 128, cache line width in bits.
- DCACHE_OFFSET_BITS, 4, line offset bits; forced to zero on every memory address.
- WB_DEPTH, 2, write-back buffer entries (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wrb_req_i  in  1  push an evicted dirty line
- wrb_addr_i  in  DCACHE_ADDR_WIDTH  line address of the evicted line
- wrb_data_i  in  DCACHE_LINE_WIDTH  evicted line data
- wrb_ready_o  out  1  buffer can accept a push this cycle
- rd_req_i  in  1  line-fill request; held until rd_ack_o
- rd_addr_i  in  DCACHE_ADDR_WIDTH  fill address
- rd_data_o  out  DCACHE_LINE_WIDTH  fill data; valid only while rd_ack_o=1
- rd_ack_o  out  1  one-cycle pulse marking fill complete
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  1 = write-back, 0 = fill read
- mem_addr_o  out  DCACHE_ADDR_WIDTH  line-aligned memory address
- mem_wdata_o  out  DCACHE_LINE_WIDTH  write-back data
- mem_rdata_i  in  DCACHE_LINE_WIDTH  read data; valid with mem_ack_i
- mem_ack_i  in  1  memory completes the current request this cycle
- wb_empty_o  out  1  no buffered lines; controller uses it as flush-done
- wb_full_o  out  1  all entries occupied

Behaviour:
- Reset (asynchronous, immediate):
  - All entries invalid; FSM goes to IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rd_ack_o=0, rd_data_o=0.
  - wb_empty_o=1, wb_full_o=0, wrb_ready_o=1.
  - An in-flight memory transaction is abandoned; its late mem_ack_i is ignored.
- Line match: compare addr[DCACHE_ADDR_WIDTH-1:DCACHE_OFFSET_BITS] only.
- Push (wrb_req_i && wrb_ready_o):
  - If a valid entry other than the in-flight head matches, overwrite its data in place (coalesce); no new entry.
  - Otherwise append at the tail.
  - wrb_ready_o = !wb_full_o, with no same-cycle pop bypass. A push on the cycle a full buffer pops is refused.
  - A coalesce into a full buffer is still refused (ready is purely !full).
- FSM states: IDLE, FWD, RD_MEM, WR_MEM.
- IDLE, priority order:
  1. rd_req_i with a buffer match: go to FWD and capture the youngest matching entry's data.
  2. rd_req_i with no match: go to RD_MEM; mem_req_o=1, mem_we_o=0, address = rd_addr_i aligned.
  3. Buffer not empty: go to WR_MEM with the head entry; mem_req_o=1, mem_we_o=1.
- FWD: rd_ack_o=1 for one cycle with the captured data; return to IDLE. Total fill latency 2 cycles, no memory access.
- RD_MEM:
  - mem_req_o, address and data stay stable until mem_ack_i.
  - On mem_ack_i: mem_req_o drops next cycle; rd_ack_o=1 next cycle with rd_data_o = registered mem_rdata_i; return to IDLE.
- WR_MEM:
  - Hold the request until mem_ack_i.
  - On ack: pop the head; mem_req_o drops; return to IDLE. Back-to-back drains have one idle gap.
  - A fill arriving during WR_MEM waits; the drain is never aborted.
- Pointers wrap modulo WB_DEPTH; occupancy counter has width log2(WB_DEPTH)+1.
- wb_empty_o and wb_full_o are registered from the occupancy counter and update the cycle after a push or pop.
- The head entry is locked from coalesce while WR_MEM is in flight; a push to the same line appends a new entry.

Decomposition:
- Shared cache_defs package (existing) holds:
  - Address and line width constants.
  - Typedef type_wb_entry_s {valid, line_addr, data}.
  - FSM enum type_wb_bridge_state_e.
- One sub-module, dcache_wb_fifo: storage, pointers, occupancy, the match/youngest-hit search and coalesce write.
- The top level holds the FSM and the memory and fill handshakes.

Test Plan:
- Fill with empty buffer: rd_req_i, addr 0x0000_1234; memory acks after 3 cycles with data D → mem_addr_o=0x0000_1230, mem_we_o=0, rd_ack_o pulses one cycle after ack with D.
- Two pushes to 0x100 and 0x200, no reads → two write transactions in FIFO order; wb_empty_o=1 one cycle after the second ack.
- Push 0x300/A, then fill read 0x308 → FWD: rd_ack_o two cycles after the request with data A, mem_req_o never asserted for the read.
- Push 0x400/A, 0x400/B while 0x400 is not in flight → one entry holding B; exactly one write of B.
- Fill buffer to WB_DEPTH, push again during the pop cycle → wrb_ready_o=0, push refused; accepted the next cycle.
- Assert rst while RD_MEM is waiting, then send mem_ack_i → outputs return to reset values immediately; late ack produces no rd_ack_o.

Source files
------------

// File: rtl/dcache_wb_mem_bridge_pkg.sv
// Shared definitions for the data-cache write-back buffer and memory bridge.
package dcache_wb_mem_bridge_pkg;

  localparam int unsigned CD_ADDR_WIDTH  = 32;
  localparam int unsigned CD_LINE_WIDTH  = 128;
  localparam int unsigned CD_OFFSET_BITS = 4;
  localparam int unsigned CD_WB_DEPTH    = 2;

  typedef struct packed {
    logic                                      valid;
    logic [CD_ADDR_WIDTH-CD_OFFSET_BITS-1:0]   line_addr;
    logic [CD_LINE_WIDTH-1:0]                  data;
  } type_wb_entry_s;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    RD_MEM = 2'd2,
    WR_MEM = 2'd3
  } type_wb_bridge_state_e;

endpackage

// File: rtl/dcache_wb_fifo.sv
// Write-back buffer: circular storage of evicted lines with coalescing pushes
// and a youngest-match lookup for fill forwarding.
module dcache_wb_fifo
  import dcache_wb_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = CD_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH  = CD_LINE_WIDTH,
  parameter int unsigned OFFSET_BITS = CD_OFFSET_BITS,
  parameter int unsigned DEPTH       = CD_WB_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] push_line,
  input  logic [LINE_WIDTH-1:0]             push_data,
  input  logic                              pop,
  input  logic                              lock_head,
  input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] lookup_line,
  output logic                              hit,
  output logic [LINE_WIDTH-1:0]             hit_data,
  output logic [ADDR_WIDTH-1:0]             head_addr,
  output logic [LINE_WIDTH-1:0]             head_data,
  output logic                              empty,
  output logic                              full
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LAW = ADDR_WIDTH - OFFSET_BITS;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [DEPTH-1:0]      valid;
  logic [LAW-1:0]        line_addr [DEPTH];
  logic [LINE_WIDTH-1:0] data      [DEPTH];
  ptr_t                  head, tail, merge_idx, idx;
  logic [PW:0]           count, count_n;
  logic                  merge;

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit       = 1'b0;
    hit_data  = '0;
    merge     = 1'b0;
    merge_idx = head;
    idx       = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + ptr_t'(i);
      if (valid[idx] && line_addr[idx] == lookup_line) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
      if (valid[idx] && line_addr[idx] == push_line && !(lock_head && idx == head)) begin
        merge     = 1'b1;
        merge_idx = idx;
      end
    end
  end

  always_comb begin
    count_n = count;
    if (push && !merge) count_n = count_n + (PW+1)'(1);
    if (pop)            count_n = count_n - (PW+1)'(1);
  end

  assign head_addr = {line_addr[head], {OFFSET_BITS{1'b0}}};
  // A coalesce into the head on the cycle a drain is launched must reach memory.
  assign head_data = (push && merge && merge_idx == head) ? push_data : data[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push && !merge) begin
        valid[tail] <= 1'b1;
        tail        <= tail + ptr_t'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + ptr_t'(1);
      end
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (merge) begin
        data[merge_idx] <= push_data;
      end else begin
        line_addr[tail] <= push_line;
        data[tail]      <= push_data;
      end
    end
  end

endmodule

// File: rtl/dcache_wb_mem_bridge.sv
// Bridge between the write-back data cache and the line-wide memory port:
// fills are served first (forwarded from the buffer when possible), dirty lines drain when idle.
module dcache_wb_mem_bridge
  import dcache_wb_mem_bridge_pkg::*;
#(
  parameter int unsigned DCACHE_ADDR_WIDTH  = CD_ADDR_WIDTH,
  parameter int unsigned DCACHE_LINE_WIDTH  = CD_LINE_WIDTH,
  parameter int unsigned DCACHE_OFFSET_BITS = CD_OFFSET_BITS,
  parameter int unsigned WB_DEPTH           = CD_WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrb_req_i,
  input  logic [DCACHE_ADDR_WIDTH-1:0] wrb_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] wrb_data_i,
  output logic                         wrb_ready_o,
  input  logic                         rd_req_i,
  input  logic [DCACHE_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DCACHE_LINE_WIDTH-1:0] rd_data_o,
  output logic                         rd_ack_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [DCACHE_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] mem_wdata_o,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_rdata_i,
  input  logic                         mem_ack_i,
  output logic                         wb_empty_o,
  output logic                         wb_full_o
);
  type_wb_bridge_state_e state, state_n;

  logic                         push, pop, hit, rd_live;
  logic                         req_n, we_n, ack_n;
  logic [DCACHE_ADDR_WIDTH-1:0] addr_n, head_addr;
  logic [DCACHE_LINE_WIDTH-1:0] wdata_n, rdata_n, hit_data, head_data;
  logic                         unused_offsets;

  assign unused_offsets = ^{wrb_addr_i[DCACHE_OFFSET_BITS-1:0], rd_addr_i[DCACHE_OFFSET_BITS-1:0]};
  assign wrb_ready_o    = !wb_full_o;
  assign push           = wrb_req_i && wrb_ready_o;
  // The requester still holds rd_req_i during its ack cycle; that request is already served.
  assign rd_live        = rd_req_i && !rd_ack_o;

  dcache_wb_fifo #(
    .ADDR_WIDTH  (DCACHE_ADDR_WIDTH),
    .LINE_WIDTH  (DCACHE_LINE_WIDTH),
    .OFFSET_BITS (DCACHE_OFFSET_BITS),
    .DEPTH       (WB_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_line   (wrb_addr_i[DCACHE_ADDR_WIDTH-1:DCACHE_OFFSET_BITS]),
    .push_data   (wrb_data_i),
    .pop         (pop),
    .lock_head   (state == WR_MEM),
    .lookup_line (rd_addr_i[DCACHE_ADDR_WIDTH-1:DCACHE_OFFSET_BITS]),
    .hit         (hit),
    .hit_data    (hit_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .empty       (wb_empty_o),
    .full        (wb_full_o)
  );

  always_comb begin
    state_n = state;
    req_n   = mem_req_o;
    we_n    = mem_we_o;
    addr_n  = mem_addr_o;
    wdata_n = mem_wdata_o;
    ack_n   = 1'b0;
    rdata_n = rd_data_o;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_live && hit) begin
          state_n = FWD;
          rdata_n = hit_data;
        end else if (rd_live) begin
          state_n = RD_MEM;
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = {rd_addr_i[DCACHE_ADDR_WIDTH-1:DCACHE_OFFSET_BITS], {DCACHE_OFFSET_BITS{1'b0}}};
        end else if (!wb_empty_o) begin
          state_n = WR_MEM;
          req_n   = 1'b1;
          we_n    = 1'b1;
          addr_n  = head_addr;
          wdata_n = head_data;
        end
      end
      FWD: begin
        ack_n   = 1'b1;
        state_n = IDLE;
      end
      RD_MEM: begin
        if (mem_ack_i) begin
          req_n   = 1'b0;
          ack_n   = 1'b1;
          rdata_n = mem_rdata_i;
          state_n = IDLE;
        end
      end
      WR_MEM: begin
        if (mem_ack_i) begin
          req_n   = 1'b0;
          pop     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rd_ack_o    <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      state       <= state_n;
      mem_req_o   <= req_n;
      mem_we_o    <= we_n;
      mem_addr_o  <= addr_n;
      mem_wdata_o <= wdata_n;
      rd_ack_o    <= ack_n;
      rd_data_o   <= rdata_n;
    end
  end

endmodule
